// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the single register-file write port between JAL link, load and ALU writeback.
// Define ARB_RR_EN for round-robin arbitration; default is fixed priority with starvation promotion.
module regfile_wr_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              jal_valid,
  input  logic [DATA_W-1:0] jal_data,
  output logic              jal_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  output logic              jal,
  output logic              reg_write,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic [7:0]        drop_cnt
);

  localparam logic [ADDR_W-1:0] LINK_REG = ADDR_W'(31);

  logic [2:0]        gnt;
  logic              jal_q, jal_d;
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

`ifdef ARB_RR_EN
  logic [1:0] ptr_q, ptr_d;

  // Search begins one past the last winner, wrapping modulo 3.
  always_comb begin
    int idx;
    logic [2:0] vld;
    gnt   = '0;
    ptr_d = ptr_q;
    vld   = {alu_valid, ld_valid, jal_valid};
    for (int i = 0; i < 3; i++) begin
      idx = (int'(ptr_q) + 1 + i) % 3;
      if (gnt == 3'b000 && vld[idx]) begin
        gnt[idx] = 1'b1;
        ptr_d    = 2'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 2'd2;
    else        ptr_q <= ptr_d;
  end
`else
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] ld_cnt_q, ld_cnt_d, alu_cnt_q, alu_cnt_d;
  logic             ld_starved, alu_starved;

  function automatic logic [CNT_W-1:0] starve_next(input logic v, input logic g,
                                                   input logic [CNT_W-1:0] c);
    if (!v || g)    return '0;
    if (c == LIMIT) return c;
    return c + CNT_W'(1);
  endfunction

  assign ld_starved  = ld_valid  && (ld_cnt_q  == LIMIT);
  assign alu_starved = alu_valid && (alu_cnt_q == LIMIT);

  always_comb begin
    gnt = '0;
    if      (ld_starved)  gnt[1] = 1'b1;
    else if (alu_starved) gnt[2] = 1'b1;
    else if (jal_valid)   gnt[0] = 1'b1;
    else if (ld_valid)    gnt[1] = 1'b1;
    else if (alu_valid)   gnt[2] = 1'b1;
  end

  assign ld_cnt_d  = starve_next(ld_valid,  gnt[1], ld_cnt_q);
  assign alu_cnt_d = starve_next(alu_valid, gnt[2], alu_cnt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_cnt_q  <= '0;
      alu_cnt_q <= '0;
    end else begin
      ld_cnt_q  <= ld_cnt_d;
      alu_cnt_q <= alu_cnt_d;
    end
  end
`endif

  assign jal_ready = gnt[0];
  assign ld_ready  = gnt[1];
  assign alu_ready = gnt[2];

  // Writes to $0 are accepted but turned into a counted drop; the port keeps its last address/data.
  always_comb begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    jal_d        = 1'b0;
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    drop_cnt_d   = drop_cnt_q;
    a            = gnt[1] ? ld_addr : alu_addr;
    d            = gnt[1] ? ld_data : alu_data;
    if (gnt[0]) begin
      jal_d        = 1'b1;
      write_reg_d  = LINK_REG;
      write_data_d = jal_data;
    end else if (gnt[1] || gnt[2]) begin
      if (a == '0) begin
        drop_cnt_d = sat_inc8(drop_cnt_q);
      end else begin
        reg_write_d  = 1'b1;
        write_reg_d  = a;
        write_data_d = d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jal_q        <= 1'b0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      jal_q        <= jal_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign jal        = jal_q;
  assign reg_write  = reg_write_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign drop_cnt   = drop_cnt_q;

endmodule
